// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared constants for the multicycle RV32I control FSM
// Holds the state encodings, the decoded opcodes, and the ALUOp / ALUSrcB control codes.
package multicycle_control_fsm_pkg;

  // Binary state encoding; codes 9..15 are unused and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control unit stepping lw/sw/R-type/beq through a multicycle datapath
// Ports:
//   clk, reset (async, active-low; forces FETCH)
//   opcode[6:0]  instr[6:0] from the IR, examined only in DECODE and MEMADR
//   RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond  write/read enables
//   ALUSrcA, MemtoReg, IorD, PCSource, ALUSrcB[1:0]             datapath mux selects
//   ALUOp[1:0]                                                  to the ALU control block
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_FETCH;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;

    case (state_q)
      S_FETCH: begin
        // Read instruction at PC and advance PC by 4 in the same cycle.
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU speculatively forms PC + imm so BRANCH can use ALUOut.
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD:  state_d = S_MEMREAD;
          OP_STORE: state_d = S_MEMWRITE;
          default:  state_d = S_FETCH;
        endcase
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_REG;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        state_d     = S_FETCH;
      end
      default: begin
        // Unused encodings: all outputs stay 0, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
// Ports: none (drives clk/reset/opcode into the DUT, checks all control outputs)
module tb_multicycle_control_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD;
  logic       IRWrite, PCWrite, PCWriteCond, PCSource;
  logic [1:0] ALUOp, ALUSrcB;

  int total = 0;
  int bad   = 0;

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .ALUSrcB    (ALUSrcB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order:
  // RegWrite ALUSrcA MemRead MemWrite MemtoReg IorD IRWrite PCWrite PCWriteCond PCSource ALUOp[1:0] ALUSrcB[1:0]
  logic [13:0] ctrl;
  assign ctrl = {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD,
                 IRWrite, PCWrite, PCWriteCond, PCSource, ALUOp, ALUSrcB};

  localparam logic [13:0] V_FETCH    = 14'b0_0_1_0_0_0_1_1_0_0_00_01;
  localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_0_0_0_0_0_00_10;
  localparam logic [13:0] V_MEMADR   = 14'b0_1_0_0_0_0_0_0_0_0_00_10;
  localparam logic [13:0] V_MEMREAD  = 14'b0_0_1_0_0_1_0_0_0_0_00_00;
  localparam logic [13:0] V_MEMWB    = 14'b1_0_0_0_1_0_0_0_0_0_00_00;
  localparam logic [13:0] V_MEMWRITE = 14'b0_0_0_1_0_1_0_0_0_0_00_00;
  localparam logic [13:0] V_EXEC     = 14'b0_1_0_0_0_0_0_0_0_0_10_00;
  localparam logic [13:0] V_ALUWB    = 14'b1_0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] V_BRANCH   = 14'b0_1_0_0_0_0_0_0_1_1_01_00;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    total++;
    assert ((MemRead & MemWrite) === 1'b0) else begin
      bad++;
      $error("FAIL %s_rd_wr_both observed=%b expected=0", tag, MemRead & MemWrite);
    end
  endtask

  // Reference: the instruction's cycle-by-cycle control words, from its class.
  task automatic run_instr(input logic [6:0] op, input string tag);
    logic [13:0] seq[$];
    seq = {V_FETCH, V_DECODE};
    if (op == LW)       seq = {seq, V_MEMADR, V_MEMREAD, V_MEMWB};
    else if (op == SW)  seq = {seq, V_MEMADR, V_MEMWRITE};
    else if (op == RT)  seq = {seq, V_EXEC, V_ALUWB};
    else if (op == BEQ) seq = {seq, V_BRANCH};
    foreach (seq[i]) begin
      // Opcode only matters in DECODE/MEMADR; scramble it elsewhere.
      if (seq[i] == V_DECODE || seq[i] == V_MEMADR) opcode = op;
      else opcode = 7'($urandom);
      #1;
      check($sformatf("%s_c%0d", tag, i), ctrl, seq[i]);
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [6:0] op;
    reset  = 1'b0;
    opcode = 7'd0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("reset_hold", ctrl, V_FETCH);
    reset = 1'b1;

    run_instr(SW, "sw");
    run_instr(LW, "lw");
    run_instr(RT, "rtype");
    run_instr(BEQ, "beq");
    run_instr(7'b0010011, "unsup");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        default: op = 7'($urandom);
      endcase
      run_instr(op, $sformatf("rnd%0d", n));
    end

    // Abort a store in MEMWRITE with reset between edges.
    opcode = 7'h7f;
    #1;
    check("abort_fetch", ctrl, V_FETCH);
    @(posedge clk); #2;
    opcode = SW;
    #1;
    check("abort_decode", ctrl, V_DECODE);
    @(posedge clk); #2;
    check("abort_memadr", ctrl, V_MEMADR);
    @(posedge clk); #2;
    opcode = 7'h00;
    #1;
    check("abort_memwrite", ctrl, V_MEMWRITE);
    reset = 1'b0;
    #1;
    check("async_reset", ctrl, V_FETCH);
    @(posedge clk); #2;
    check("reset_held_edge", ctrl, V_FETCH);
    reset = 1'b1;
    run_instr(LW, "post_reset_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
